// File: rtl/regfile.sv
// regfile: architectural integer register file with two combinational read
// ports, a write-through bypass from writeback, and a per-register
// outstanding-write scoreboard that raises stall_req on stale operands or
// counter overflow.
module regfile #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            read1,
    input  logic [AW-1:0]   reg1_addr,
    output logic [XLEN-1:0] reg1_data,
    input  logic            read2,
    input  logic [AW-1:0]   reg2_addr,
    output logic [XLEN-1:0] reg2_data,
    input  logic            issue_write,
    input  logic [AW-1:0]   issue_addr,
    input  logic            wb_write,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall_req
);

    localparam int unsigned NREG = 1 << AW;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [CNTW-1:0] cnt_q  [NREG];
    logic [CNTW-1:0] cnt_d  [NREG];

    logic [CNTW-1:0] cnt1, cnt2, cnt_iss;
    logic            wb_hit1, wb_hit2, wb_hit_iss;
    logic            hazard1, hazard2, overflow;

    // Read ports: x0 and disabled ports read zero, commit bypass wins over storage.
    always_comb begin
        reg1_data = '0;
        reg2_data = '0;
        if (!reset && read1 && reg1_addr != '0) begin
            if (wb_write && wb_addr == reg1_addr) reg1_data = wb_data;
            else                                  reg1_data = regs_q[reg1_addr];
        end
        if (!reset && read2 && reg2_addr != '0) begin
            if (wb_write && wb_addr == reg2_addr) reg2_data = wb_data;
            else                                  reg2_data = regs_q[reg2_addr];
        end
    end

    // Hazard and overflow detection from current counts; a same-cycle commit
    // resolves a single outstanding write and frees one overflow slot.
    always_comb begin
        cnt1       = cnt_q[reg1_addr];
        cnt2       = cnt_q[reg2_addr];
        cnt_iss    = cnt_q[issue_addr];
        wb_hit1    = wb_write && (wb_addr == reg1_addr);
        wb_hit2    = wb_write && (wb_addr == reg2_addr);
        wb_hit_iss = wb_write && (wb_addr == issue_addr) && (cnt_iss != '0);
        hazard1    = read1 && (reg1_addr != '0) &&
                     ((cnt1 > CNT_ONE) || ((cnt1 == CNT_ONE) && !wb_hit1));
        hazard2    = read2 && (reg2_addr != '0) &&
                     ((cnt2 > CNT_ONE) || ((cnt2 == CNT_ONE) && !wb_hit2));
        overflow   = issue_write && (issue_addr != '0) &&
                     (cnt_iss == CNT_MAX) && !wb_hit_iss;
        stall_req  = !reset && (hazard1 || hazard2 || overflow);
    end

    // Next-state for storage and scoreboard; flush clears counts but not data.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wb_write && wb_addr != '0) regs_d[wb_addr] = wb_data;
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            logic inc, dec;
            inc = issue_write && (issue_addr == AW'(r)) && !stall_req;
            dec = wb_write && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
            if (flush)            cnt_d[r] = '0;
            else if (inc && !dec) cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
    end

    // State registers with synchronous reset of data and counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed test-plan steps followed by random traffic, each cycle
// checked against an arithmetic reference model of the register file.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        read1, read2;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic        issue_write;
    logic [4:0]  issue_addr;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall_req;

    regfile #(.XLEN(32), .AW(5), .CNTW(2)) dut (
        .clk(clk), .reset(reset),
        .read1(read1), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
        .read2(read2), .reg2_addr(reg2_addr), .reg2_data(reg2_data),
        .issue_write(issue_write), .issue_addr(issue_addr),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [31:0] m_read(bit rst, bit rd, int a, bit wb, int wa, logic [31:0] wd);
        if (rst || !rd || a == 0) return 32'h0;
        if (wb && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_hazard(bit rd, int a, bit wb, int wa);
        if (!rd || a == 0) return 1'b0;
        return (m_cnt[a] >= 2) || (m_cnt[a] == 1 && !(wb && wa == a));
    endfunction

    task automatic step(string tag, bit rst, bit r1, int a1, bit r2, int a2,
                        bit iw, int ia, bit wb, int wa, logic [31:0] wd, bit fl);
        logic [31:0] e1, e2;
        bit          es, ovf;
        reset = rst; read1 = r1; reg1_addr = 5'(a1); read2 = r2; reg2_addr = 5'(a2);
        issue_write = iw; issue_addr = 5'(ia); wb_write = wb; wb_addr = 5'(wa);
        wb_data = wd; flush = fl;
        #1;
        e1  = m_read(rst, r1, a1, wb, wa, wd);
        e2  = m_read(rst, r2, a2, wb, wa, wd);
        ovf = iw && ia != 0 && m_cnt[ia] == 3 && !(wb && wa == ia);
        es  = !rst && (m_hazard(r1, a1, wb, wa) || m_hazard(r2, a2, wb, wa) || ovf);
        n_total++;
        assert (reg1_data === e1) n_pass++;
        else $error("FAIL %s reg1_data got %h exp %h", tag, reg1_data, e1);
        n_total++;
        assert (reg2_data === e2) n_pass++;
        else $error("FAIL %s reg2_data got %h exp %h", tag, reg2_data, e2);
        n_total++;
        assert (stall_req === es) n_pass++;
        else $error("FAIL %s stall_req got %b exp %b", tag, stall_req, es);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
        end else begin
            if (wb && wa != 0) m_regs[wa] = wd;
            if (fl) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                if (wb && wa != 0 && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
                if (iw && ia != 0 && !es) m_cnt[ia] = m_cnt[ia] + 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_regs[i] = 'x; m_cnt[i] = 0; end
        reset = 1'b1; read1 = 0; read2 = 0; reg1_addr = 0; reg2_addr = 0;
        issue_write = 0; issue_addr = 0; wb_write = 0; wb_addr = 0; wb_data = 0; flush = 0;
        @(negedge clk);

        // Reset with busy inputs: outputs forced quiet.
        step("rst_busy", 1, 1, 5, 1, 6, 1, 3, 1, 5, 32'hFFFF_0000, 0);
        step("rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        for (int a = 0; a < 32; a++)
            step("rd_all", 0, 1, a, 1, 31 - a, 0, 0, 0, 0, 32'h0, 0);
        step("x0_wr", 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
        step("x0_rd", 0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);

        // Bypass then storage.
        step("x5_byp", 0, 1, 5, 0, 0, 0, 0, 1, 5, 32'h1234_5678, 0);
        step("x5_rd",  0, 1, 5, 1, 5, 0, 0, 0, 0, 32'h0, 0);

        // RAW hazard on x7.
        step("x7_iss",  0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0, 0);
        step("x7_haz",  0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0, 0);
        step("x7_cmt",  0, 0, 0, 1, 7, 0, 0, 1, 7, 32'hA5A5_A5A5, 0);
        step("x7_free", 0, 1, 7, 1, 7, 0, 0, 0, 0, 32'h0, 0);

        // Counter saturation on x3.
        step("x3_i1",   0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0);
        step("x3_i2",   0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0);
        step("x3_i3",   0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0);
        step("x3_ovf",  0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0);
        step("x3_iwc",  0, 0, 0, 0, 0, 1, 3, 1, 3, 32'h33, 0);
        step("x3_ovf2", 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0);
        step("x3_c1",   0, 1, 3, 0, 0, 0, 0, 1, 3, 32'h31, 0);
        step("x3_c2",   0, 1, 3, 0, 0, 0, 0, 1, 3, 32'h32, 0);
        step("x3_c3",   0, 1, 3, 0, 0, 0, 0, 1, 3, 32'h34, 0);
        step("x3_free", 0, 1, 3, 1, 3, 0, 0, 0, 0, 32'h0, 0);

        // Flush on x9, then stale commit must not underflow.
        step("x9_i1",   0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
        step("x9_i2",   0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
        step("x9_fl",   0, 1, 9, 0, 0, 1, 9, 0, 0, 32'h0, 1);
        step("x9_rd",   0, 1, 9, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("x9_stal", 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h1, 0);
        step("x9_rd2",  0, 1, 9, 1, 9, 0, 0, 0, 0, 32'h0, 0);
        step("x9_iss",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
        step("x9_haz",  0, 1, 9, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("x9_cmt",  0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0);

        // Reset mid-flight on x4.
        step("x4_wr",   0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 0);
        step("x4_iss",  0, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0, 0);
        step("x4_rst",  1, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("x4_rd",   0, 1, 4, 1, 4, 0, 0, 0, 0, 32'h0, 0);
        step("x4_cmt",  0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h4444, 0);
        step("x4_iss2", 0, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0, 0);
        step("x4_haz",  0, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 0);

        // Populate every register so random reads compare known values.
        for (int a = 1; a < 32; a++)
            step("fill", 0, 0, 0, 0, 0, 0, 0, 1, a, $urandom, 0);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            step("rand", ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                 ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file with a per-register outstanding-write scoreboard. It serves the decode stage's two read ports (`read1`/`reg1_addr`/`reg1_data`, `read2`/`reg2_addr`/`reg2_data`) and accepts commits from writeback. It tracks in-flight destination registers issued by decode and raises `stall_req` whenever decode would consume a stale operand. It sits between `stage_id` (reader/issuer) and the writeback stage (writer).

## Interface
Parameters:
- `XLEN`, 32: register width; matches `RegBus`.
- `AW`, 5: register address width; matches `RegAddrBus`.
- `CNTW`, 2: width of each outstanding-write counter. The maximum number of in-flight writes per register is 2^CNTW-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `read1` in 1: port-1 read enable.
- `reg1_addr` in AW: port-1 address.
- `reg1_data` out XLEN: port-1 data (combinational).
- `read2` in 1: port-2 read enable.
- `reg2_addr` in AW: port-2 address.
- `reg2_data` out XLEN: port-2 data (combinational).
- `issue_write` in 1: decode is issuing an instruction that will write `issue_addr`.
- `issue_addr` in AW: destination of the issuing instruction.
- `wb_write` in 1: writeback commit valid.
- `wb_addr` in AW: commit destination.
- `wb_data` in XLEN: commit data.
- `flush` in 1: discard all in-flight tracking (pipeline squash).
- `stall_req` out 1: decode must hold; the current issue is not accepted.

## Operation
- Storage: `regs[1..2^AW-1]`, XLEN bits each. `x0` reads 0, ignores writes, and is never tracked.
- Read port N, evaluated independently per port:
  - `readN`=0 or address 0: output 0.
  - Else if `wb_write` and `wb_addr`==address: output `wb_data` (write-through bypass).
  - Else: output `regs[address]`.
- Commit: at the edge, if `wb_write` and `wb_addr`≠0, `regs[wb_addr]` ← `wb_data`.
- Scoreboard: `cnt[r]`, CNTW bits per register r≠0.
  - dec(r) = `wb_write` and `wb_addr`==r and `cnt[r]`≠0.
  - inc(r) = `issue_write` and `issue_addr`==r and `stall_req`=0.
  - Next value: `cnt[r]` + inc − dec. Simultaneous inc and dec leaves `cnt[r]` unchanged.
  - A commit to a register with `cnt`=0 writes data but does not touch `cnt` (no underflow).
- Hazard for port N: `readN`=1, address≠0, and either:
  - `cnt[address]`≥2, or
  - `cnt[address]`==1 and not (`wb_write` and `wb_addr`==address).
- Issue overflow: `issue_write`=1, `issue_addr`≠0, and `cnt[issue_addr]` is at its maximum, unless a dec(`issue_addr`) occurs this cycle.
- `stall_req` = hazard1 | hazard2 | overflow. It is purely combinational and must have no path from `stall_req` back into its own inputs.
- `flush` (non-reset): clears every `cnt` to 0 at the edge and ignores inc that cycle. The commit in the same cycle still updates `regs`.

## Timing
- Reset (`reset`=1 at edge): all `regs` ← 0, all `cnt` ← 0. While `reset`=1, `reg1_data`=`reg2_data`=0 and `stall_req`=0, regardless of other inputs.
- Read latency 0 cycles. A committed value is visible combinationally in the commit cycle via bypass, and from `regs` in every later cycle.
- A scoreboard update takes effect the cycle after the edge. An issue at edge k makes a dependent read at cycle k+1 stall.
- Priority at an edge: `reset` > `flush` > inc/dec.
- Reset asserted mid-operation discards all in-flight counts. Writeback commits after reset are accepted as plain writes with no underflow.

## Test plan
- Reset, then read x0..x31 on both ports -> all data 0, `stall_req`=0; a commit of 0xDEADBEEF to x0, then a read of x0 -> 0.
- Commit x5=0x12345678 with `read1` of x5 in the same cycle -> `reg1_data`=0x12345678 (bypass); the next cycle, without a commit -> still 0x12345678.
- Issue x7 (`stall_req`=0), next cycle `read2` of x7 with no commit -> `stall_req`=1; the following cycle commit x7=0xA5A5A5A5 -> `stall_req`=0 and `reg2_data`=0xA5A5A5A5; `cnt[x7]` returns to 0.
- Issue x3 three times (CNTW=2), then a fourth issue of x3 -> `stall_req`=1 and `cnt` stays 3; commit x3 in the same cycle as the fourth issue -> `stall_req`=0 and `cnt` stays 3.
- Issue x9 twice, then assert `flush` -> the next cycle reading x9 gives `stall_req`=0; the subsequent stale commit x9=0x1 writes `regs` and `cnt` stays 0.
- Issue x4, then assert `reset` mid-flight -> the next cycle `stall_req`=0 and `reg1_data` for x4=0.
